// File: rtl/hazard_forward_unit.sv
// Pipeline hazard controller: EX operand-forward selects plus IF/ID stall and flush.
// Define HAZARD_FWD_EN to enable forwarding; otherwise dependent instructions stall until the writer retires.
module hazard_forward_unit #(
  parameter int unsigned REG_W  = 4,
  parameter int unsigned PC_REG = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] rs1D,
  input  logic [REG_W-1:0] rs2D,
  input  logic             use1D,
  input  logic             use2D,
  input  logic [REG_W-1:0] rdD,
  input  logic             regWriteD,
  input  logic             memReadD,
  input  logic             branchTakenE,
  output logic             Fa,
  output logic             Fb,
  output logic             FaSrc,
  output logic             FbSrc,
  output logic             stallF,
  output logic             stallD,
  output logic             flushD,
  output logic             flushE
);

  localparam logic [REG_W-1:0] PC_IDX = REG_W'(PC_REG);

  logic [REG_W-1:0] r_rdE, r_rdM, r_rdW;
  logic             r_wrE, r_wrM, r_wrW;
  logic             w_hitE, w_hazard;
  logic             w_fa, w_fa_src, w_fb, w_fb_src;

  // Destination scoreboard; a flushed E slot becomes a bubble
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rdE <= '0;
      r_rdM <= '0;
      r_rdW <= '0;
      r_wrE <= 1'b0;
      r_wrM <= 1'b0;
      r_wrW <= 1'b0;
    end else begin
      r_rdE <= rdD;
      r_wrE <= regWriteD && !flushE;
      r_rdM <= r_rdE;
      r_wrM <= r_wrE;
      r_rdW <= r_rdM;
      r_wrW <= r_wrM;
    end
  end

  assign w_hitE = r_wrE && (r_rdE != PC_IDX) &&
                  ((use1D && (rs1D == r_rdE)) || (use2D && (rs2D == r_rdE)));

`ifdef HAZARD_FWD_EN
  logic [REG_W-1:0] r_rs1E, r_rs2E;
  logic             r_use1E, r_use2E, r_ldE, r_ldM;
  logic             w_fwd_m1, w_fwd_w1, w_fwd_m2, w_fwd_w2;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rs1E  <= '0;
      r_rs2E  <= '0;
      r_use1E <= 1'b0;
      r_use2E <= 1'b0;
      r_ldE   <= 1'b0;
      r_ldM   <= 1'b0;
    end else begin
      r_rs1E  <= rs1D;
      r_rs2E  <= rs2D;
      r_use1E <= use1D && !flushE;
      r_use2E <= use2D && !flushE;
      r_ldE   <= memReadD && !flushE;
      r_ldM   <= r_ldE;
    end
  end

  // A load in M has no data yet, so only W may supply it
  assign w_fwd_m1 = r_use1E && r_wrM && !r_ldM && (r_rdM == r_rs1E) && (r_rs1E != PC_IDX);
  assign w_fwd_w1 = r_use1E && r_wrW && (r_rdW == r_rs1E) && (r_rs1E != PC_IDX);
  assign w_fwd_m2 = r_use2E && r_wrM && !r_ldM && (r_rdM == r_rs2E) && (r_rs2E != PC_IDX);
  assign w_fwd_w2 = r_use2E && r_wrW && (r_rdW == r_rs2E) && (r_rs2E != PC_IDX);

  assign w_fa     = w_fwd_m1 || w_fwd_w1;
  assign w_fa_src = !w_fwd_m1 && w_fwd_w1;
  assign w_fb     = w_fwd_m2 || w_fwd_w2;
  assign w_fb_src = !w_fwd_m2 && w_fwd_w2;
  assign w_hazard = w_hitE && r_ldE;
`else
  logic w_hitM, w_hitW, w_unused;

  assign w_hitM = r_wrM && (r_rdM != PC_IDX) &&
                  ((use1D && (rs1D == r_rdM)) || (use2D && (rs2D == r_rdM)));
  assign w_hitW = r_wrW && (r_rdW != PC_IDX) &&
                  ((use1D && (rs1D == r_rdW)) || (use2D && (rs2D == r_rdW)));

  assign w_fa     = 1'b0;
  assign w_fa_src = 1'b0;
  assign w_fb     = 1'b0;
  assign w_fb_src = 1'b0;
  assign w_hazard = w_hitE || w_hitM || w_hitW;
  assign w_unused = memReadD;
`endif

  // A taken branch flushes and always overrides a stall
  always_comb begin
    Fa     = w_fa;
    FaSrc  = w_fa_src;
    Fb     = w_fb;
    FbSrc  = w_fb_src;
    stallF = 1'b0;
    stallD = 1'b0;
    flushD = 1'b0;
    flushE = 1'b0;
    if (branchTakenE) begin
      flushD = 1'b1;
      flushE = 1'b1;
    end else if (w_hazard) begin
      stallF = 1'b1;
      stallD = 1'b1;
      flushE = 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Self-checking bench for hazard_forward_unit: directed scenarios plus random traffic against an instruction-level model.
module tb_hazard_forward_unit;

  typedef struct packed {
    logic [3:0] rs1;
    logic [3:0] rs2;
    logic [3:0] rd;
    logic       u1;
    logic       u2;
    logic       wr;
    logic       ld;
  } ins_t;

  logic clk, rst, br;
  ins_t d, mE, mM, mW;
  logic [7:0] last_exp;
  int checks, errors;

  logic Fa, Fb, FaSrc, FbSrc, stallF, stallD, flushD, flushE;
  logic [7:0] obs;
  assign obs = {Fa, FaSrc, Fb, FbSrc, stallF, stallD, flushD, flushE};

  hazard_forward_unit #(.REG_W(4), .PC_REG(15)) dut (
    .clk(clk), .rst(rst),
    .rs1D(d.rs1), .rs2D(d.rs2), .use1D(d.u1), .use2D(d.u2),
    .rdD(d.rd), .regWriteD(d.wr), .memReadD(d.ld), .branchTakenE(br),
    .Fa(Fa), .Fb(Fb), .FaSrc(FaSrc), .FbSrc(FbSrc),
    .stallF(stallF), .stallD(stallD), .flushD(flushD), .flushE(flushE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic ins_t mk(input logic [3:0] rs1, input logic u1, input logic [3:0] rs2,
                              input logic u2, input logic [3:0] rd, input logic wr, input logic ld);
    ins_t t;
    t.rs1 = rs1; t.u1 = u1; t.rs2 = rs2; t.u2 = u2; t.rd = rd; t.wr = wr; t.ld = ld;
    return t;
  endfunction

`ifdef HAZARD_FWD_EN
  // Source of an EX operand: youngest usable producer, loads in M not usable
  function automatic logic [1:0] fwd_sel(input logic [3:0] rs, input logic u);
    if (!u || rs == 4'd15) return 2'b00;
    if (mM.wr && mM.rd == rs && !mM.ld) return 2'b10;
    if (mW.wr && mW.rd == rs) return 2'b11;
    return 2'b00;
  endfunction
`endif

  // Expected {Fa,FaSrc,Fb,FbSrc,stallF,stallD,flushD,flushE}
  function automatic logic [7:0] model_exp();
    ins_t st[3];
    logic haz;
    logic [1:0] fa, fb;
    logic [7:0] e;
    st[0] = mE; st[1] = mM; st[2] = mW;
    fa = 2'b00; fb = 2'b00; haz = 1'b0;
`ifdef HAZARD_FWD_EN
    fa = fwd_sel(mE.rs1, mE.u1);
    fb = fwd_sel(mE.rs2, mE.u2);
    haz = mE.ld && mE.wr && mE.rd != 4'd15 &&
          ((d.u1 && d.rs1 == mE.rd) || (d.u2 && d.rs2 == mE.rd));
`else
    for (int i = 0; i < 3; i++)
      if (st[i].wr && st[i].rd != 4'd15 &&
          ((d.u1 && d.rs1 == st[i].rd) || (d.u2 && d.rs2 == st[i].rd)))
        haz = 1'b1;
`endif
    e = {fa, fb, 4'b0000};
    if (br) e[1:0] = 2'b11;
    else if (haz) begin e[3] = 1'b1; e[2] = 1'b1; e[0] = 1'b1; end
    return e;
  endfunction

  task automatic tick();
    last_exp = model_exp();
    @(posedge clk);
    if (!rst) begin
      mE = '0; mM = '0; mW = '0;
    end else begin
      mW = mM;
      mM = mE;
      mE = last_exp[0] ? ins_t'('0) : d;
    end
    #1;
  endtask

  task automatic drain();
    d = '0; br = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_reset();
    rst = 1'b0; br = 1'b0;
    d = mk(4'd1, 1'b1, 4'd2, 1'b1, 4'd3, 1'b1, 1'b0);
    tick(); tick();
    @(negedge clk);
    checks++;
    if (obs !== 8'h00) begin errors++; $display("FAIL reset_idle: got %b expected %b", obs, 8'h00); end
    br = 1'b1; #1;
    checks++;
    if (obs !== 8'h03) begin errors++; $display("FAIL reset_branch: got %b expected %b", obs, 8'h03); end
    br = 1'b0; rst = 1'b1;
    tick();
    @(negedge clk);
    checks++;
    if (obs !== 8'h00) begin errors++; $display("FAIL first_cycle: got %b expected %b", obs, 8'h00); end
    drain();
  endtask

  task automatic test_forward_alu();
`ifdef HAZARD_FWD_EN
    d = mk(4'd0, 1'b0, 4'd0, 1'b0, 4'd1, 1'b1, 1'b0); tick();
    d = mk(4'd1, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (obs !== 8'h00) begin errors++; $display("FAIL alu_b2b_nostall: got %b expected %b", obs, 8'h00); end
    tick(); d = '0;
    @(negedge clk);
    checks++;
    if (obs !== 8'h80) begin errors++; $display("FAIL alu_b2b_fwdM: got %b expected %b", obs, 8'h80); end
    drain();
    d = mk(4'd0, 1'b0, 4'd0, 1'b0, 4'd2, 1'b1, 1'b0); tick();
    d = mk(4'd0, 1'b0, 4'd0, 1'b0, 4'd6, 1'b1, 1'b0); tick();
    d = mk(4'd0, 1'b0, 4'd2, 1'b1, 4'd0, 1'b0, 1'b0); tick();
    d = '0;
    @(negedge clk);
    checks++;
    if (obs !== 8'h30) begin errors++; $display("FAIL dist2_fwdW: got %b expected %b", obs, 8'h30); end
    drain();
    d = mk(4'd0, 1'b0, 4'd0, 1'b0, 4'd3, 1'b1, 1'b0); tick();
    d = mk(4'd0, 1'b0, 4'd0, 1'b0, 4'd3, 1'b1, 1'b0); tick();
    d = mk(4'd3, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0); tick();
    d = '0;
    @(negedge clk);
    checks++;
    if (obs !== 8'h80) begin errors++; $display("FAIL m_priority: got %b expected %b", obs, 8'h80); end
    drain();
`else
    d = mk(4'd0, 1'b0, 4'd0, 1'b0, 4'd5, 1'b1, 1'b0); tick();
    d = mk(4'd5, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (obs !== 8'h0D) begin errors++; $display("FAIL nofwd_stall%0d: got %b expected %b", k, obs, 8'h0D); end
      tick();
    end
    @(negedge clk);
    checks++;
    if (obs !== 8'h00) begin errors++; $display("FAIL nofwd_release: got %b expected %b", obs, 8'h00); end
    tick(); d = '0;
    @(negedge clk);
    checks++;
    if (obs !== 8'h00) begin errors++; $display("FAIL nofwd_no_fa: got %b expected %b", obs, 8'h00); end
    drain();
`endif
  endtask

  task automatic test_load_use();
    d = mk(4'd0, 1'b0, 4'd0, 1'b0, 4'd4, 1'b1, 1'b1); tick();
    d = mk(4'd4, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (obs !== 8'h0D) begin errors++; $display("FAIL load_use_stall: got %b expected %b", obs, 8'h0D); end
    tick();
`ifdef HAZARD_FWD_EN
    @(negedge clk);
    checks++;
    if (obs !== 8'h00) begin errors++; $display("FAIL load_use_single: got %b expected %b", obs, 8'h00); end
    tick(); d = '0;
    @(negedge clk);
    checks++;
    if (obs !== 8'hC0) begin errors++; $display("FAIL load_use_fwdW: got %b expected %b", obs, 8'hC0); end
`else
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (obs !== 8'h0D) begin errors++; $display("FAIL load_nofwd_stall: got %b expected %b", obs, 8'h0D); end
      tick();
    end
    @(negedge clk);
    checks++;
    if (obs !== 8'h00) begin errors++; $display("FAIL load_nofwd_release: got %b expected %b", obs, 8'h00); end
`endif
    drain();
  endtask

  task automatic test_branch();
    d = mk(4'd0, 1'b0, 4'd0, 1'b0, 4'd4, 1'b1, 1'b1); tick();
    d = mk(4'd4, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0); br = 1'b1;
    @(negedge clk);
    checks++;
    if (obs !== 8'h03) begin errors++; $display("FAIL branch_over_stall: got %b expected %b", obs, 8'h03); end
    tick();
    drain();
    d = mk(4'd0, 1'b0, 4'd0, 1'b0, 4'd15, 1'b1, 1'b0); tick();
    d = mk(4'd15, 1'b1, 4'd15, 1'b1, 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (obs !== 8'h00) begin errors++; $display("FAIL pc_no_stall: got %b expected %b", obs, 8'h00); end
    tick(); d = '0;
    @(negedge clk);
    checks++;
    if (obs !== 8'h00) begin errors++; $display("FAIL pc_no_forward: got %b expected %b", obs, 8'h00); end
    drain();
  endtask

  task automatic test_reset_mid_stall();
    d = mk(4'd0, 1'b0, 4'd0, 1'b0, 4'd4, 1'b1, 1'b1); tick();
    d = mk(4'd4, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (obs !== 8'h0D) begin errors++; $display("FAIL midrst_stall: got %b expected %b", obs, 8'h0D); end
    rst = 1'b0;
    tick();
    @(negedge clk);
    checks++;
    if (obs !== 8'h00) begin errors++; $display("FAIL midrst_cleared: got %b expected %b", obs, 8'h00); end
    rst = 1'b1;
    drain();
  endtask

  task automatic test_random();
    logic [7:0] exp_v;
    logic [3:0] r1, r2, rd;
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 39) != 0);
      br  = ($urandom_range(0, 7) == 0);
      if (last_exp[1]) d = '0;
      else if (!last_exp[2]) begin
        r1 = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 5));
        r2 = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 5));
        rd = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 5));
        d = mk(r1, 1'($urandom_range(0, 1)), r2, 1'($urandom_range(0, 1)), rd,
               1'b0, 1'b0);
        d.wr = ($urandom_range(0, 3) != 0);
        d.ld = d.wr && ($urandom_range(0, 3) == 0);
      end
      @(negedge clk);
      exp_v = model_exp();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL random_cycle%0d: got %b expected %b", n, obs, exp_v);
      end
      tick();
    end
    rst = 1'b1;
    drain();
  endtask

  initial begin
    checks = 0; errors = 0;
    mE = '0; mM = '0; mW = '0; last_exp = '0;
    rst = 1'b0; br = 1'b0; d = '0;
    test_reset();
    test_forward_alu();
    test_load_use();
    test_branch();
    test_reset_mid_stall();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_forward_unit.md
# hazard_forward_unit

Pipeline hazard controller that produces the operand-forwarding selects `Fa`/`Fb` consumed by the EX-stage operand multiplexers, together with the fetch/decode stall and flush controls. It keeps its own registered scoreboard of in-flight destination registers for the EX, MEM and WB stages. From that scoreboard it resolves read-after-write hazards by forwarding where possible and by stalling on load-use. It sits beside the datapath pipeline registers and is driven from the decode stage and the EX-stage branch outcome.

## Interface
- `REG_W`, 4: register-address width.
- `PC_REG`, 15: register index aliased to the PC. It is never forwarded and never causes a stall.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-low reset.
- `rs1D`, `rs2D` input REG_W: source registers of the instruction in decode.
- `use1D`, `use2D` input 1: the decode instruction actually reads `rs1D`/`rs2D`.
- `rdD` input REG_W: destination of the decode instruction.
- `regWriteD` input 1: the decode instruction writes `rdD`.
- `memReadD` input 1: the decode instruction is a load.
- `branchTakenE` input 1: branch/jump resolved taken in EX this cycle.
- `Fa`, `Fb` output 1: forward enable for operand A/B in EX.
- `FaSrc`, `FbSrc` output 1: forward source; 0 = ALU output of MEM stage, 1 = WB result.
- `stallF`, `stallD` output 1: hold the PC and the IF/ID register.
- `flushD`, `flushE` output 1: clear the IF/ID and ID/EX registers to a bubble.

## Operation
- Scoreboard registers:
  - E stage: `rs1E`, `rs2E`, `use1E`, `use2E`, `rdE`, `wrE`, `ldE`.
  - M stage: `rdM`, `wrM`.
  - W stage: `rdW`, `wrW`.
- Advance every cycle: D→E, E→M, M→W.
- When `flushE`=1, E loads a bubble: all use/wr/ld bits 0. M and W still advance.
- Forward A:
  - `Fa`=1, `FaSrc`=0 if `use1E` && `wrM` && `rdM`==`rs1E` && `rs1E`!=`PC_REG`.
  - Otherwise `Fa`=1, `FaSrc`=1 if the same test holds against W.
  - Otherwise both are 0.
  - M has priority over W.
  - B uses the identical rules with `rs2E`.
- Load-use hazard: `ldE` && `wrE` && `rdE`!=`PC_REG` && ((`use1D` && `rs1D`==`rdE`) || (`use2D` && `rs2D`==`rdE`)).
  - On a hazard: `stallF`=`stallD`=1 and `flushE`=1 for exactly one cycle.
  - On the next cycle the load is in M. It cannot forward from M, so it resolves through W one cycle later. The stall is therefore re-evaluated against M with `ldM` (an internal M-stage copy of `ldE`): a load in M matching E sources also forces a forward from W only. Forwarding from M is suppressed while `ldM`=1.
- Branch taken: `flushD`=`flushE`=1 and `stallF`=`stallD`=0. A flush always overrides a stall in the same cycle.

## Timing
- All outputs are combinational from the inputs and the scoreboard. There is no added latency.
- While `rst`=0 at a clock edge, all scoreboard valid bits (`use*`, `wr*`, `ld*`) clear.
- All outputs are 0 during reset and in the first cycle after reset, unless `branchTakenE`=1.
- A reset asserted mid-stall ends the stall on the next edge. No hazard state survives reset.
- A register compare is an exact REG_W-bit equality. There is no wrap or width extension.
- A load-use stall plus a taken branch in the same cycle gives flushD=1, flushE=1, stallF=0, stallD=0.

## Configuration
- `HAZARD_FWD_EN` defined: forwarding as described above. The only stall is the one-cycle load-use stall.
- `HAZARD_FWD_EN` undefined:
  - `Fa`=`Fb`=`FaSrc`=`FbSrc`=0 always.
  - `stallF`=`stallD`=`flushE`=1 whenever a used D source matches a valid writer in E, M or W (excluding `PC_REG`).
  - Dependent instructions therefore stall up to 3 cycles.
  - The branch flush rules are unchanged.

## Test plan
- ALU→ALU back-to-back: `r1←`, then an instruction with rs1=1 → in its EX cycle `Fa`=1, `FaSrc`=0, no stall.
- Distance two: writer rd=2, one independent instruction, then reader rs2=2 → `Fb`=1, `FbSrc`=1.
- Both writers match, rd=3 in M and W → `Fa`=1, `FaSrc`=0 (M wins).
- Load rd=4, then a reader rs1=4 → one cycle with stallF=stallD=flushE=1, then `Fa`=1, `FaSrc`=1, with no second stall.
- Load-use hazard coincident with branchTakenE=1 → flushD=flushE=1, stallF=stallD=0. rd=15 writers never forward.
- With `HAZARD_FWD_EN` undefined: ALU rd=5, then a reader rs1=5 → stall for 3 consecutive cycles, then release with `Fa`=0. Pulling `rst` low in cycle 2 clears the stall on the next edge.
